// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the memory arbiter slice.
//   state_t : arbiter FSM state (IDLE, ACCESS, DONE)
//   owner_t : which requester owns the current transfer (fetch / load-store)
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the load/store port and the shared
// memory port of mem_arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives done/rdata/mem_*)
//   master : client / memory-model side (the reverse)
// Parameters: AW address width, DW data width.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_done;
  logic [DW-1:0] ls_rdata;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_done, if_rdata, ls_done, ls_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_done, if_rdata, ls_done, ls_rdata,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_wait_cnt.sv
// mem_arb_wait_cnt: 4-bit down-counter timing the ACCESS phase.
//   clk, rst  : clock, synchronous active-high reset (clears count)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load (LAT-1)
//   dec       : decrement by one; saturates at zero
//   zero      : count is zero
module mem_arb_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port and a
// load/store port. Each transfer runs IDLE -> ACCESS (LAT cycles, mem_cs=1)
// -> DONE (one-cycle done pulse to the owner) -> IDLE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (fetch, load/store and memory signals)
//   busy     : high whenever the FSM is not in IDLE
// Parameters: AW, DW widths; LAT access cycles per transfer (1..15).
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between the
// two requesters; default is fixed priority with load/store first.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t        state;
  owner_t        owner;
  owner_t        grant;
  logic          any_req;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

`ifdef MEM_ARB_RR_EN
  owner_t last_own;

  // On a tie the requester that did not win the previous grant goes first.
  always_comb begin
    grant = OWN_IF;
    if (bus.ls_req && bus.if_req)
      grant = (last_own == OWN_LS) ? OWN_IF : OWN_LS;
    else if (bus.ls_req)
      grant = OWN_LS;
  end
`else
  always_comb begin
    grant = OWN_IF;
    if (bus.ls_req)
      grant = OWN_LS;
  end
`endif

  assign any_req   = bus.if_req || bus.ls_req;
  assign addr_sel  = (grant == OWN_LS) ? bus.ls_addr : bus.if_addr;
  assign wdata_sel = (grant == OWN_LS) ? bus.ls_wdata : bus.mem_wdata;
  assign cnt_load  = (state == IDLE) && any_req;
  assign cnt_dec   = (state == ACCESS) && !cnt_zero;
  assign busy      = (state != IDLE);

  mem_arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_M1),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      bus.mem_cs    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_done   <= 1'b0;
      bus.ls_done   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.ls_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      last_own      <= OWN_IF;
`endif
    end else begin
      bus.if_done <= 1'b0;
      bus.ls_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner         <= grant;
            bus.mem_cs    <= 1'b1;
            bus.mem_we    <= (grant == OWN_LS) && bus.ls_we;
            bus.mem_addr  <= addr_sel;
            bus.mem_wdata <= wdata_sel;
            state         <= ACCESS;
`ifdef MEM_ARB_RR_EN
            last_own      <= grant;
`endif
          end
        end
        ACCESS: begin
          // Read data is taken on the final access edge; done is raised here
          // so that it is a registered pulse covering exactly the DONE cycle.
          if (cnt_zero) begin
            bus.mem_cs <= 1'b0;
            bus.mem_we <= 1'b0;
            if (owner == OWN_LS) begin
              bus.ls_done <= 1'b1;
              if (!bus.mem_we)
                bus.ls_rdata <= bus.mem_rdata;
            end else begin
              bus.if_done  <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
